// File: rtl/pe_pkg.sv
// Shared PE-array types and default geometry.
// Used by the PE array, its sequencer and their benches.
// Holds instruction/algorithm encodings and the sequencer state type.
package pe_pkg;

  localparam int PE_WIDTH   = 24;
  localparam int PE_NUM     = 4;
  localparam int PE_IN_NUM  = 3;
  localparam int PE_OUT_NUM = 2;
  localparam int PE_ADDR_W  = 8;
  localparam int PE_LATENCY = 3;

  typedef enum logic [4:0] {
    MADD    = 5'd0,
    MSUB    = 5'd1,
    MMUL    = 5'd2,
    NTT_BF  = 5'd3,
    INTT_BF = 5'd4
  } pe_instr_t;

  typedef enum logic [4:0] {
    KEM_512  = 5'd0,
    KEM_768  = 5'd1,
    KEM_1024 = 5'd2,
    DSA_44   = 5'd3,
    DSA_65   = 5'd4,
    DSA_87   = 5'd5
  } pe_alg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/pe_seq_pipe.sv
// Beat-valid and write-address delay line for the PE sequencer.
// Latency: DEPTH cycles from vld_i/addr_i to the last stage; every stage is visible on vld_o.
// Backpressure: none, shifts every cycle; rst clears all stages synchronously.
// Ports: clk, rst, vld_i, addr_i in; vld_o (all stages, [0] = one cycle old), addr_o (last stage) out.
module pe_seq_pipe #(
  parameter int DEPTH  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DEPTH-1:0]  vld_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= {vld_q[DEPTH-2:0], vld_i};
      addr_q <= {addr_q[DEPTH-2:0], addr_i};
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/pe_array_seq.sv
// PE array sequencer: one vector command -> N coefficient-memory reads, PE issue, N write-backs, done pulse.
// Latency: accept at T gives rd_en at T+1+k, wr_en at T+3+k+PE_LAT, done at T+3+N+PE_LAT.
// Backpressure: cmd_ready only in IDLE; memory and PE array are never stalled.
// Ports: cmd_* (command in), rd_* (read port), pe_* (PE array), wr_* (write port), busy/done status.
module pe_array_seq
  import pe_pkg::*;
#(
  parameter int WIDTH   = PE_WIDTH,
  parameter int NUM     = PE_NUM,
  parameter int IN_NUM  = PE_IN_NUM,
  parameter int OUT_NUM = PE_OUT_NUM,
  parameter int ADDR_W  = PE_ADDR_W,
  parameter int PE_LAT  = PE_LATENCY
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  pe_instr_t                             cmd_instr,
  input  pe_alg_t                               cmd_alg,
  input  logic [ADDR_W-1:0]                     cmd_src_base,
  input  logic [ADDR_W-1:0]                     cmd_dst_base,
  input  logic [ADDR_W:0]                       cmd_beats,
  output logic                                  rd_en,
  output logic [ADDR_W-1:0]                     rd_addr,
  input  logic [NUM-1:0][IN_NUM-1:0][WIDTH-1:0]  rd_data,
  output pe_instr_t                             pe_instr,
  output pe_alg_t                               pe_alg,
  output logic [NUM-1:0][IN_NUM-1:0][WIDTH-1:0]  pe_data_in,
  input  logic [NUM-1:0][OUT_NUM-1:0][WIDTH-1:0] pe_data_out,
  output logic                                  wr_en,
  output logic [ADDR_W-1:0]                     wr_addr,
  output logic [NUM-1:0][OUT_NUM-1:0][WIDTH-1:0] wr_data,
  output logic                                  busy,
  output logic                                  done
);

  // Read issue -> data return (1) -> operand register (1) -> PE pipeline.
  localparam int            DEPTH     = 2 + PE_LAT;
  localparam logic [ADDR_W:0] MAX_BEATS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  seq_state_t                           state_q, state_d;
  pe_instr_t                            instr_q, instr_d;
  pe_alg_t                              alg_q, alg_d;
  logic [ADDR_W-1:0]                    src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]                      beats_q, beats_d, cnt_q, cnt_d;
  logic [NUM-1:0][IN_NUM-1:0][WIDTH-1:0] opnd_q;
  logic                                 issue;
  logic [DEPTH-1:0]                     pipe_vld;
  logic [ADDR_W-1:0]                    pipe_addr;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    alg_d   = alg_q;
    src_d   = src_q;
    dst_d   = dst_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          instr_d = cmd_instr;
          alg_d   = cmd_alg;
          src_d   = cmd_src_base;
          dst_d   = cmd_dst_base;
          cnt_d   = '0;
          beats_d = (cmd_beats > MAX_BEATS) ? MAX_BEATS : cmd_beats;
          state_d = (cmd_beats == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        cnt_d = cnt_q + ONE;
        if (cnt_q == beats_q - ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Reads have stopped, so a write with nothing behind it is the last one.
        if (pipe_vld[DEPTH-1] && !(|pipe_vld[DEPTH-2:0])) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= MADD;
      alg_q   <= KEM_512;
      src_q   <= '0;
      dst_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      alg_q   <= alg_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      // Stage 0 marks the cycle the memory returns a requested beat.
      if (pipe_vld[0]) opnd_q <= rd_data;
    end
  end

  pe_seq_pipe #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (issue),
    .addr_i (dst_q + cnt_q[ADDR_W-1:0]),
    .vld_o  (pipe_vld),
    .addr_o (pipe_addr)
  );

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign rd_en      = issue;
  assign rd_addr    = src_q + cnt_q[ADDR_W-1:0];
  assign pe_instr   = instr_q;
  assign pe_alg     = alg_q;
  assign pe_data_in = opnd_q;
  assign wr_en      = pipe_vld[DEPTH-1];
  assign wr_addr    = pipe_addr;
  assign wr_data    = pe_data_out;

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq with a behavioural memory and a 3-cycle PE model.
// Inputs are driven 1 time unit after the rising edge; the event monitor samples on the falling edge.
// Cycle numbers are relative to the cycle in which the command is accepted.
module tb_pe_array_seq;
  import pe_pkg::*;

  localparam longint Q = 8380417;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       cmd_valid = 1'b0;
  logic                       cmd_ready;
  pe_instr_t                  cmd_instr = MADD;
  pe_alg_t                    cmd_alg = KEM_512;
  logic [7:0]                 cmd_src_base = '0;
  logic [7:0]                 cmd_dst_base = '0;
  logic [8:0]                 cmd_beats = '0;
  logic                       rd_en;
  logic [7:0]                 rd_addr;
  logic [3:0][2:0][23:0]      rd_data;
  pe_instr_t                  pe_instr;
  pe_alg_t                    pe_alg;
  logic [3:0][2:0][23:0]      pe_data_in;
  logic [3:0][1:0][23:0]      pe_data_out;
  logic                       wr_en;
  logic [7:0]                 wr_addr;
  logic [3:0][1:0][23:0]      wr_data;
  logic                       busy;
  logic                       done;

  pe_array_seq dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_instr    (cmd_instr),
    .cmd_alg      (cmd_alg),
    .cmd_src_base (cmd_src_base),
    .cmd_dst_base (cmd_dst_base),
    .cmd_beats    (cmd_beats),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .pe_instr     (pe_instr),
    .pe_alg       (pe_alg),
    .pe_data_in   (pe_data_in),
    .pe_data_out  (pe_data_out),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done)
  );

  // Coefficient memory: read data appears the cycle after rd_en.
  logic [3:0][2:0][23:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // PE model: out0 = a*b mod Q, out1 = (a+c) mod Q, three cycles after pe_data_in.
  logic [3:0][1:0][23:0] pe_s1, pe_s2, pe_s3;
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      pe_s1[p][0] <= 24'((longint'(pe_data_in[p][0]) * longint'(pe_data_in[p][1])) % Q);
      pe_s1[p][1] <= 24'((longint'(pe_data_in[p][0]) + longint'(pe_data_in[p][2])) % Q);
    end
    pe_s2 <= pe_s1;
    pe_s3 <= pe_s2;
  end
  assign pe_data_out = pe_s3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$], done_cyc[$], acc_cyc[$];
  longint wr_d0[$], wr_d1[$];

  always @(negedge clk) begin
    if (rd_en) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(int'(rd_addr));
    end
    if (wr_en) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(int'(wr_addr));
      wr_d0.push_back(longint'(wr_data[0][0]));
      wr_d1.push_back(longint'(wr_data[0][1]));
    end
    if (done) done_cyc.push_back(cyc);
    if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
    done_cyc.delete(); acc_cyc.delete(); wr_d0.delete(); wr_d1.delete();
  endtask

  // Presents a command until accepted; returns in the cycle after acceptance.
  task automatic start(input pe_instr_t ins, input pe_alg_t alg, input logic [7:0] src,
                       input logic [7:0] dst, input logic [8:0] beats);
    int n = 0;
    tick();
    cmd_instr = ins; cmd_alg = alg; cmd_src_base = src; cmd_dst_base = dst;
    cmd_beats = beats; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  function automatic int t0();
    return (acc_cyc.size() > 0) ? acc_cyc[0] : 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_r[4];
    int exp_w[4];
    for (int a = 0; a < 256; a++)
      for (int p = 0; p < 4; p++)
        for (int i = 0; i < 3; i++)
          mem[a][p][i] = 24'(a * 16 + p * 4 + i + 1);
    mem[16][0][0] = 24'd100000;
    mem[16][0][1] = 24'd8191000;
    mem[16][0][2] = 24'd5;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_pe_instr", pe_instr, MADD);
    check("rst_pe_alg", pe_alg, KEM_512);
    check("rst_pe_data_in_zero", (pe_data_in == '0) ? 1 : 0, 1);
    rst = 1'b0;
    tick();

    // Basic 4-beat MMUL command
    clear_q();
    start(MMUL, DSA_44, 8'h10, 8'h80, 9'd4);
    check("t1_busy", busy, 1);
    check("t1_pe_instr", pe_instr, MMUL);
    wait_done(60);
    tick();
    check("t1_ready_after", cmd_ready, 1);
    tick(); tick();
    check("t1_acc_n", acc_cyc.size(), 1);
    check("t1_rd_n", rd_cyc.size(), 4);
    for (int k = 0; k < rd_cyc.size() && k < 4; k++) begin
      check("t1_rd_cyc", rd_cyc[k] - t0(), 1 + k);
      check("t1_rd_addr", rd_adr[k], 16 + k);
    end
    check("t1_wr_n", wr_cyc.size(), 4);
    for (int k = 0; k < wr_cyc.size() && k < 4; k++) begin
      check("t1_wr_cyc", wr_cyc[k] - t0(), 6 + k);
      check("t1_wr_addr", wr_adr[k], 128 + k);
    end
    check("t1_done_n", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("t1_done_cyc", done_cyc[0] - t0(), 10);
    if (wr_d0.size() > 1) begin
      check("t1_wr_data_b0_mul", wr_d0[0], 6422837);
      check("t1_wr_data_b0_add", wr_d1[0], 100005);
      check("t1_wr_data_b1_mul", wr_d0[1], 74802);
    end
    check("t1_instr_retained", pe_instr, MMUL);
    check("t1_alg_retained", pe_alg, DSA_44);

    // Zero beats
    clear_q();
    start(MADD, KEM_768, 8'h00, 8'h00, 9'd0);
    check("z_done", done, 1);
    check("z_ready_in_done", cmd_ready, 0);
    tick();
    check("z_ready_back", cmd_ready, 1);
    check("z_done_gone", done, 0);
    tick(); tick();
    check("z_rd_n", rd_cyc.size(), 0);
    check("z_wr_n", wr_cyc.size(), 0);
    if (done_cyc.size() > 0) check("z_done_cyc", done_cyc[0] - t0(), 1);
    else check("z_done_n", 0, 1);

    // Back-to-back with cmd_valid held
    clear_q();
    tick();
    cmd_instr = NTT_BF; cmd_alg = KEM_768; cmd_src_base = 8'h20; cmd_dst_base = 8'h40;
    cmd_beats = 9'd2; cmd_valid = 1'b1;
    tick();
    cmd_instr = MSUB; cmd_alg = DSA_65; cmd_src_base = 8'h30; cmd_dst_base = 8'h50;
    check("b2b_instr_first", pe_instr, NTT_BF);
    wait_done(40);
    check("b2b_instr_at_done", pe_instr, NTT_BF);
    tick();
    check("b2b_ready", cmd_ready, 1);
    check("b2b_instr_idle", pe_instr, NTT_BF);
    tick();
    check("b2b_instr_second", pe_instr, MSUB);
    check("b2b_alg_second", pe_alg, DSA_65);
    check("b2b_busy_second", busy, 1);
    cmd_valid = 1'b0;
    wait_done(40);
    tick(); tick();
    check("b2b_acc_n", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2 && done_cyc.size() == 2 && rd_cyc.size() == 4 && wr_cyc.size() == 4) begin
      check("b2b_acc_gap", acc_cyc[1] - acc_cyc[0], 9);
      check("b2b_acc_after_done", acc_cyc[1], done_cyc[0] + 1);
      check("b2b_rd2_cyc", rd_cyc[2] - acc_cyc[1], 1);
      check("b2b_rd2_addr", rd_adr[2], 48);
      check("b2b_wr3_addr", wr_adr[3], 81);
    end else begin
      check("b2b_event_counts", 0, 1);
    end

    // Address wrap
    clear_q();
    exp_r = '{254, 255, 0, 1};
    exp_w = '{255, 0, 1, 2};
    start(MADD, KEM_1024, 8'hFE, 8'hFF, 9'd4);
    wait_done(60);
    tick(); tick();
    check("wrap_rd_n", rd_adr.size(), 4);
    check("wrap_wr_n", wr_adr.size(), 4);
    for (int k = 0; k < rd_adr.size() && k < 4; k++) check("wrap_rd_addr", rd_adr[k], exp_r[k]);
    for (int k = 0; k < wr_adr.size() && k < 4; k++) check("wrap_wr_addr", wr_adr[k], exp_w[k]);

    // Reset in the middle of a 10-beat command
    clear_q();
    start(MADD, KEM_512, 8'h00, 8'h00, 9'd10);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mrst_rd_en", rd_en, 0);
    check("mrst_wr_en", wr_en, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", cmd_ready, 1);
    rst = 1'b0;
    repeat (20) tick();
    check("mrst_done_n", done_cyc.size(), 0);
    check("mrst_rd_n", rd_cyc.size(), 3);
    check("mrst_wr_n", wr_cyc.size(), 0);

    // Beat-count clamp
    clear_q();
    start(MMUL, KEM_512, 8'h00, 8'h00, 9'd300);
    wait_done(400);
    tick(); tick(); tick();
    check("clamp_rd_n", rd_cyc.size(), 256);
    check("clamp_wr_n", wr_cyc.size(), 256);
    check("clamp_done_n", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("clamp_done_cyc", done_cyc[0] - t0(), 262);
    if (rd_adr.size() == 256) check("clamp_rd_last", rd_adr[255], 255);
    if (wr_cyc.size() == 256) begin
      check("clamp_wr_last_cyc", wr_cyc[255] - t0(), 261);
      check("clamp_wr_last_addr", wr_adr[255], 255);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
